// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
// Holds the controller FSM encoding and the "no interrupt" ID value.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } irq_state_e;

    localparam int unsigned IRQ_ID_NONE = 0;

    // Returns the ID (index + 1) of the lowest set bit, or 0 when no bit is set.
    function automatic logic [5:0] first_set_id(input logic [31:0] vec);
        first_set_id = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                first_set_id = 6'(i + 1);
            end
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous level interrupt line.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o
);

    // [0] and [1] form the synchronizer, [2] remembers the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered, non-nesting external interrupt controller with fixed
// lowest-index priority. Optional machine timer enabled by IRQ_CTRL_TIMER_EN.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq,
    input  logic [NSRC-1:0] src_en,
    input  logic            meie,
    input  logic            mie,
    output logic            ex_interrupt,
    output logic [IDW-1:0]  irq_id,
    input  logic            ack,
    input  logic            complete,
    output logic [NSRC-1:0] pending
`ifdef IRQ_CTRL_TIMER_EN
    ,
    input  logic [31:0]     tcmp_wdata,
    input  logic            tcmp_wen,
    input  logic            tcmp_hi,
    output logic            timer_irq
`endif
);

    irq_state_e      state_q, state_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] rise_det;
    logic [NSRC-1:0] sel_dec;
    logic [NSRC-1:0] clr_mask;
    logic [31:0]     cand_vec;
    logic [IDW-1:0]  cand_id;
    logic            irq_enabled;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            irq_sync_edge u_sync_edge (
                .clk    (clk),
                .rst    (rst),
                .din_i  (src_irq[gi]),
                .rise_o (rise_det[gi])
            );

            // One-hot decode of the ID in service, used to clear its pending bit on ack.
            assign sel_dec[gi] = (irq_id_q == IDW'(gi + 1));
        end
    endgenerate

    assign cand_vec    = 32'(pending_q & src_en);
    assign cand_id     = IDW'(first_set_id(cand_vec));
    assign irq_enabled = meie & mie;

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (irq_enabled && (cand_vec != 32'd0)) begin
                    irq_id_d = cand_id;
                    state_d  = ST_REQ;
                end else begin
                    irq_id_d = IDW'(IRQ_ID_NONE);
                end
            end
            ST_REQ: begin
                // A taken trap outranks a same-cycle enable drop.
                if (ack) begin
                    clr_mask = sel_dec;
                    state_d  = ST_SERV;
                end else if (!irq_enabled) begin
                    irq_id_d = IDW'(IRQ_ID_NONE);
                    state_d  = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (complete) begin
                    irq_id_d = IDW'(IRQ_ID_NONE);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                irq_id_d = IDW'(IRQ_ID_NONE);
                state_d  = ST_IDLE;
            end
        endcase
        // New edges win over the acknowledge clear of the same bit.
        pending_d = (pending_q & ~clr_mask) | rise_det;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            irq_id_q  <= IDW'(IRQ_ID_NONE);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
        end
    end

    assign ex_interrupt = (state_q == ST_REQ);
    assign irq_id       = irq_id_q;
    assign pending      = pending_q;

`ifdef IRQ_CTRL_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (tcmp_wen) begin
            if (tcmp_hi) begin
                mtimecmp_d[63:32] = tcmp_wdata;
            end else begin
                mtimecmp_d[31:0] = tcmp_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= {64{1'b1}};
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign timer_irq = (mtime_q >= mtimecmp_q);
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed plus randomized bench for irq_ctrl, checked against a
// cycle-level behavioural model of the interrupt rules.
module tb_irq_ctrl;

    localparam int NSRC = 8;
    localparam int IDW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src_irq;
    logic [NSRC-1:0] src_en;
    logic            meie;
    logic            mie;
    logic            ex_interrupt;
    logic [IDW-1:0]  irq_id;
    logic            ack;
    logic            complete;
    logic [NSRC-1:0] pending;
`ifdef IRQ_CTRL_TIMER_EN
    logic [31:0]     tcmp_wdata;
    logic            tcmp_wen;
    logic            tcmp_hi;
    logic            timer_irq;
    logic [63:0]     m_mtime;
    logic [63:0]     m_cmp;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: pending vector, last sampled levels, 2-deep edge delay line,
    // whether a request is presented / in service, and the expected ID.
    logic [NSRC-1:0] m_pend, m_prev, m_r1, m_r2;
    bit              m_presenting, m_in_service;
    int              m_id;

    irq_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_irq      (src_irq),
        .src_en       (src_en),
        .meie         (meie),
        .mie          (mie),
        .ex_interrupt (ex_interrupt),
        .irq_id       (irq_id),
        .ack          (ack),
        .complete     (complete),
        .pending      (pending)
`ifdef IRQ_CTRL_TIMER_EN
        ,
        .tcmp_wdata   (tcmp_wdata),
        .tcmp_wen     (tcmp_wen),
        .tcmp_hi      (tcmp_hi),
        .timer_irq    (timer_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend       = '0;
        m_prev       = '0;
        m_r1         = '0;
        m_r2         = '0;
        m_presenting = 1'b0;
        m_in_service = 1'b0;
        m_id         = 0;
`ifdef IRQ_CTRL_TIMER_EN
        m_mtime      = 64'd0;
        m_cmp        = {64{1'b1}};
`endif
    endtask

    // Advance one clock, apply the interrupt rules to the model, then compare.
    task automatic step();
        logic [NSRC-1:0] rise, set, clr;
        int cand;
        @(posedge clk);
        rise   = src_irq & ~m_prev;
        m_prev = src_irq;
        set    = m_r2;
        m_r2   = m_r1;
        m_r1   = rise;
        clr    = '0;
        if (m_presenting) begin
            if (ack) begin
                clr[m_id-1]  = 1'b1;
                m_presenting = 1'b0;
                m_in_service = 1'b1;
            end else if (!(meie && mie)) begin
                m_presenting = 1'b0;
                m_id         = 0;
            end
        end else if (m_in_service) begin
            if (complete) begin
                m_in_service = 1'b0;
                m_id         = 0;
            end
        end else begin
            cand = 0;
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (m_pend[i] && src_en[i]) cand = i + 1;
            end
            if (cand != 0 && meie && mie) begin
                m_presenting = 1'b1;
                m_id         = cand;
            end else begin
                m_id = 0;
            end
        end
        m_pend = (m_pend & ~clr) | set;
`ifdef IRQ_CTRL_TIMER_EN
        if (tcmp_wen) begin
            if (tcmp_hi) m_cmp[63:32] = tcmp_wdata;
            else         m_cmp[31:0]  = tcmp_wdata;
        end
        m_mtime = m_mtime + 64'd1;
`endif
        #1;
        chk("ex_interrupt", 64'(ex_interrupt), 64'(m_presenting));
        chk("irq_id", 64'(irq_id), 64'(m_id));
        chk("pending", 64'(pending), 64'(m_pend));
`ifdef IRQ_CTRL_TIMER_EN
        chk("timer_irq", 64'(timer_irq), 64'(m_mtime >= m_cmp));
`endif
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_complete();
        complete = 1'b1;
        step();
        complete = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        src_irq  = '0;
        src_en   = '1;
        meie     = 1'b1;
        mie      = 1'b1;
        ack      = 1'b0;
        complete = 1'b0;
`ifdef IRQ_CTRL_TIMER_EN
        tcmp_wdata = 32'd0;
        tcmp_wen   = 1'b0;
        tcmp_hi    = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex", 64'(ex_interrupt), 64'd0);
        chk("reset_id", 64'(irq_id), 64'd0);
        chk("reset_pend", 64'(pending), 64'd0);
        rst = 1'b0;

`ifdef IRQ_CTRL_TIMER_EN
        // Timer: compare value 10 fires once mtime reaches it; all-ones silences it.
        tcmp_wen = 1'b1; tcmp_hi = 1'b1; tcmp_wdata = 32'd0;
        step();
        tcmp_hi = 1'b0; tcmp_wdata = 32'd10;
        step();
        tcmp_wen = 1'b0;
        repeat (10) step();
        chk("timer_fired", 64'(timer_irq), 64'd1);
        tcmp_wen = 1'b1; tcmp_hi = 1'b0; tcmp_wdata = 32'hFFFF_FFFF;
        step();
        tcmp_hi = 1'b1;
        step();
        tcmp_wen = 1'b0;
        step();
        chk("timer_cleared", 64'(timer_irq), 64'd0);
`endif

        // Single request: source 2, ID 3, 3 cycles to pending and 4 to request.
        src_irq[2] = 1'b1;
        repeat (3) step();
        chk("lat_pending", 64'(pending[2]), 64'd1);
        chk("lat_no_ex_yet", 64'(ex_interrupt), 64'd0);
        step();
        chk("single_ex", 64'(ex_interrupt), 64'd1);
        chk("single_id", 64'(irq_id), 64'd3);
        src_irq = '0;
        step();
        chk("hold_id", 64'(irq_id), 64'd3);
        pulse_ack();
        chk("ack_pend_clr", 64'(pending[2]), 64'd0);
        chk("ack_ex_low", 64'(ex_interrupt), 64'd0);
        pulse_complete();
        chk("complete_id0", 64'(irq_id), 64'd0);

        // Priority: sources 5 and 1 together, ID 2 first then ID 6.
        src_irq = 8'b0010_0010;
        repeat (4) step();
        chk("prio_first", 64'(irq_id), 64'd2);
        src_irq = '0;
        pulse_ack();
        pulse_complete();
        step();
        chk("prio_second", 64'(irq_id), 64'd6);
        chk("prio_second_ex", 64'(ex_interrupt), 64'd1);
        pulse_ack();
        pulse_complete();

        // Masking: disabled source pends without requesting until enabled.
        src_en = 8'hFE;
        src_irq[0] = 1'b1;
        repeat (6) step();
        chk("mask_pend", 64'(pending[0]), 64'd1);
        chk("mask_no_ex", 64'(ex_interrupt), 64'd0);
        src_en = 8'hFF;
        step();
        chk("unmask_ex", 64'(ex_interrupt), 64'd1);
        chk("unmask_id", 64'(irq_id), 64'd1);
        src_irq = '0;
        pulse_ack();
        pulse_complete();

        // No nesting: source 0 edges while ID 4 is in service.
        src_irq[3] = 1'b1;
        repeat (4) step();
        pulse_ack();
        src_irq = 8'b0000_0001;
        repeat (6) step();
        chk("nest_no_ex", 64'(ex_interrupt), 64'd0);
        chk("nest_keep_id", 64'(irq_id), 64'd4);
        pulse_complete();
        step();
        chk("nest_after_id", 64'(irq_id), 64'd1);
        src_irq = '0;
        pulse_ack();
        pulse_complete();

        // Enable drop while requesting returns to idle with pending kept.
        src_irq[6] = 1'b1;
        repeat (4) step();
        mie = 1'b0;
        step();
        chk("drop_ex", 64'(ex_interrupt), 64'd0);
        chk("drop_pend", 64'(pending[6]), 64'd1);
        mie = 1'b1;
        step();
        chk("drop_reissue", 64'(irq_id), 64'd7);
        src_irq = '0;
        pulse_ack();
        pulse_complete();

        // Asynchronous reset while requesting, observed before any clock edge.
        src_irq[4] = 1'b1;
        repeat (4) step();
        chk("pre_rst_ex", 64'(ex_interrupt), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_ex", 64'(ex_interrupt), 64'd0);
        chk("async_rst_pend", 64'(pending), 64'd0);
        chk("async_rst_id", 64'(irq_id), 64'd0);
        src_irq = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic, including stray ack/complete and re-edges in service.
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(15) == 0) src_irq[b] = ~src_irq[b];
            end
            if ($urandom_range(31) == 0) src_en = NSRC'($urandom) | NSRC'($urandom);
            meie     = ($urandom_range(19) != 0);
            mie      = ($urandom_range(19) != 0);
            ack      = m_presenting ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            complete = ($urandom_range(5) == 0);
            step();
        end
        ack      = 1'b0;
        complete = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
